// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with valid/ready handshake, one-entry skid buffer,
// synchronous flush, control bubbling and a saturating stall-cycle counter.
module id_ex_pipe_reg #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned EX_CTRL_W  = 6,
  parameter int unsigned MEM_CTRL_W = 4,
  parameter int unsigned WB_CTRL_W  = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_rs_data,
  input  logic [XLEN-1:0]       in_rt_data,
  input  logic [XLEN-1:0]       in_imm,
  input  logic [REG_AW-1:0]     in_rt,
  input  logic [REG_AW-1:0]     in_rd,
  input  logic [EX_CTRL_W-1:0]  in_ex_ctrl,
  input  logic [MEM_CTRL_W-1:0] in_mem_ctrl,
  input  logic [WB_CTRL_W-1:0]  in_wb_ctrl,
  input  logic [XLEN-1:0]       in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_rs_data,
  output logic [XLEN-1:0]       out_rt_data,
  output logic [XLEN-1:0]       out_imm,
  output logic [REG_AW-1:0]     out_rt,
  output logic [REG_AW-1:0]     out_rd,
  output logic [EX_CTRL_W-1:0]  out_ex_ctrl,
  output logic [MEM_CTRL_W-1:0] out_mem_ctrl,
  output logic [WB_CTRL_W-1:0]  out_wb_ctrl,
  output logic [XLEN-1:0]       out_pc,
  output logic [1:0]            occupancy,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int unsigned PW = 4 * XLEN + 2 * REG_AW + EX_CTRL_W + MEM_CTRL_W + WB_CTRL_W;

  logic [PW-1:0]         in_bus;
  logic [PW-1:0]         main_q;
  logic [PW-1:0]         skid_q;
  logic                  main_valid_q;
  logic                  skid_valid_q;
  logic [CNT_W-1:0]      stall_cnt_q;
  logic                  accept;
  logic [EX_CTRL_W-1:0]  ex_raw;
  logic [MEM_CTRL_W-1:0] mem_raw;
  logic [WB_CTRL_W-1:0]  wb_raw;

  assign in_bus = {in_rs_data, in_rt_data, in_imm, in_pc, in_rt, in_rd,
                   in_ex_ctrl, in_mem_ctrl, in_wb_ctrl};

  // in_ready comes straight from a flop, so it never depends on out_ready.
  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      if (main_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (flush) begin
        // Payload is left in place; only the valid bits are squashed.
        main_valid_q <= 1'b0;
        skid_valid_q <= 1'b0;
      end else if (!main_valid_q || out_ready) begin
        if (skid_valid_q) begin
          main_q       <= skid_q;
          main_valid_q <= 1'b1;
          if (accept) begin
            skid_q <= in_bus;
          end
          skid_valid_q <= accept;
        end else begin
          if (accept) begin
            main_q <= in_bus;
          end
          main_valid_q <= accept;
        end
      end else if (accept) begin
        skid_q       <= in_bus;
        skid_valid_q <= 1'b1;
      end
    end
  end

  assign {out_rs_data, out_rt_data, out_imm, out_pc, out_rt, out_rd,
          ex_raw, mem_raw, wb_raw} = main_q;

  // Invalid entries present as bubbles: control groups read as zero.
  assign out_ex_ctrl  = main_valid_q ? ex_raw  : '0;
  assign out_mem_ctrl = main_valid_q ? mem_raw : '0;
  assign out_wb_ctrl  = main_valid_q ? wb_raw  : '0;

  assign out_valid = main_valid_q;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: directed handshake/flush/reset cases,
// then a long random in_valid/out_ready run against a FIFO model.
module tb_id_ex_pipe_reg;

  localparam int BW = 4 * 32 + 2 * 5 + 6 + 4 + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_rs_data = '0, in_rt_data = '0, in_imm = '0, in_pc = '0;
  logic [4:0]  in_rt = '0, in_rd = '0;
  logic [5:0]  in_ex_ctrl = '0;
  logic [3:0]  in_mem_ctrl = '0;
  logic [1:0]  in_wb_ctrl = '0;

  logic        in_ready, out_valid;
  logic [31:0] out_rs_data, out_rt_data, out_imm, out_pc;
  logic [4:0]  out_rt, out_rd;
  logic [5:0]  out_ex_ctrl;
  logic [3:0]  out_mem_ctrl;
  logic [1:0]  out_wb_ctrl;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;

  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_rs_data, s_out_rt_data, s_out_imm, s_out_pc;
  logic [4:0]  s_out_rt, s_out_rd;
  logic [5:0]  s_out_ex_ctrl;
  logic [3:0]  s_out_mem_ctrl;
  logic [1:0]  s_out_wb_ctrl;
  logic [1:0]  s_occupancy;
  logic [2:0]  s_stall_cnt;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  logic [BW-1:0] sb_q[$];

  id_ex_pipe_reg dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm), .in_rt(in_rt),
    .in_rd(in_rd), .in_ex_ctrl(in_ex_ctrl), .in_mem_ctrl(in_mem_ctrl),
    .in_wb_ctrl(in_wb_ctrl), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_rs_data(out_rs_data), .out_rt_data(out_rt_data), .out_imm(out_imm),
    .out_rt(out_rt), .out_rd(out_rd), .out_ex_ctrl(out_ex_ctrl),
    .out_mem_ctrl(out_mem_ctrl), .out_wb_ctrl(out_wb_ctrl), .out_pc(out_pc),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  // Narrow-counter instance on the same stimulus, used for saturation.
  id_ex_pipe_reg #(.CNT_W(3)) dut_small (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm), .in_rt(in_rt),
    .in_rd(in_rd), .in_ex_ctrl(in_ex_ctrl), .in_mem_ctrl(in_mem_ctrl),
    .in_wb_ctrl(in_wb_ctrl), .in_pc(in_pc), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_rs_data(s_out_rs_data), .out_rt_data(s_out_rt_data), .out_imm(s_out_imm),
    .out_rt(s_out_rt), .out_rd(s_out_rd), .out_ex_ctrl(s_out_ex_ctrl),
    .out_mem_ctrl(s_out_mem_ctrl), .out_wb_ctrl(s_out_wb_ctrl), .out_pc(s_out_pc),
    .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] in_bundle();
    return {in_rs_data, in_rt_data, in_imm, in_pc, in_rt, in_rd,
            in_ex_ctrl, in_mem_ctrl, in_wb_ctrl};
  endfunction

  function automatic logic [BW-1:0] out_bundle();
    return {out_rs_data, out_rt_data, out_imm, out_pc, out_rt, out_rd,
            out_ex_ctrl, out_mem_ctrl, out_wb_ctrl};
  endfunction

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Fields derived from pc so every entry is distinct; controls never all-zero.
  task automatic drive(input logic v, input logic [31:0] pc);
    in_valid    = v;
    in_pc       = pc;
    in_rs_data  = pc ^ 32'hA5A5_0000;
    in_rt_data  = ~pc;
    in_imm      = {pc[29:0], 2'b01};
    in_rt       = pc[6:2];
    in_rd       = pc[6:2] + 5'd1;
    in_ex_ctrl  = pc[7:2] | 6'h01;
    in_mem_ctrl = pc[5:2] | 4'h1;
    in_wb_ctrl  = pc[3:2] | 2'h1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: sees pre-edge state on the falling edge, pops on out-transfers,
  // then updates the model with this cycle's flush/reset/accept.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!out_valid)
        check("bubble_ctrl", {out_ex_ctrl, out_mem_ctrl, out_wb_ctrl}, '0);
      check("occupancy", occupancy, sb_q.size());
      check("in_ready", in_ready, sb_q.size() != 2);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_output actual_pc=%0h required=none", out_pc);
        end else begin
          check("fifo_order", out_bundle(), sb_q.pop_front());
        end
      end
      if (rst || flush) sb_q.delete();
      else if (in_valid && in_ready) sb_q.push_back(in_bundle());
    end
  end

  initial begin
    drive(1'b0, 32'h0);
    step();
    step();
    mon_en = 1'b1;
    rst = 1'b0;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_occupancy", occupancy, 2'd0);
    check("rst_stall_cnt", stall_cnt, 16'd0);
    check("rst_payload", out_bundle(), '0);

    // Streaming: one-cycle latency, occupancy never above 1.
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'(i * 4));
      step();
      check("stream_valid", out_valid, 1'b1);
      check("stream_pc", out_pc, 32'(i * 4));
      check("stream_occ_le1", occupancy <= 2'd1, 1'b1);
    end
    drive(1'b0, 32'h0);
    step();
    check("stream_drained", out_valid, 1'b0);

    // Back-pressure into the skid, then stall counting and saturation.
    out_ready = 1'b0;
    drive(1'b1, 32'h04);
    step();
    drive(1'b1, 32'h08);
    step();
    drive(1'b0, 32'h0);
    check("bp_occupancy", occupancy, 2'd2);
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_out_pc", out_pc, 32'h04);
    repeat (4) step();
    check("stall_cnt_5", stall_cnt, 16'd5);
    check("stall_small_5", s_stall_cnt, 3'd5);
    repeat (5) step();
    check("stall_cnt_10", stall_cnt, 16'd10);
    check("stall_small_sat", s_stall_cnt, 3'd7);
    out_ready = 1'b1;
    step();
    check("bp_second_pc", out_pc, 32'h08);
    check("bp_in_ready_back", in_ready, 1'b1);
    check("bp_occ_1", occupancy, 2'd1);
    step();
    check("bp_empty", out_valid, 1'b0);
    check("stall_cnt_hold", stall_cnt, 16'd10);

    // Flush at occupancy 2 with a new input offered.
    out_ready = 1'b0;
    drive(1'b1, 32'h14);
    step();
    drive(1'b1, 32'h18);
    step();
    check("fl_occ_2", occupancy, 2'd2);
    drive(1'b1, 32'h20);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0);
    check("fl_out_valid", out_valid, 1'b0);
    check("fl_occupancy", occupancy, 2'd0);
    check("fl_ctrl_zero", {out_ex_ctrl, out_mem_ctrl, out_wb_ctrl}, '0);
    check("fl_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (3) step();
    check("fl_no_0x20", out_valid, 1'b0);

    // Reset mid-stream at occupancy 2.
    out_ready = 1'b0;
    drive(1'b1, 32'h24);
    step();
    drive(1'b1, 32'h28);
    step();
    check("rs_occ_2", occupancy, 2'd2);
    drive(1'b0, 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rs_out_valid", out_valid, 1'b0);
    check("rs_in_ready", in_ready, 1'b1);
    check("rs_occupancy", occupancy, 2'd0);
    check("rs_stall_cnt", stall_cnt, 16'd0);
    check("rs_stall_small", s_stall_cnt, 3'd0);
    check("rs_payload", out_bundle(), '0);

    // Random handshake traffic checked entirely by the monitor.
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(1)), $urandom);
      out_ready = 1'($urandom_range(1));
      flush = ($urandom_range(31) == 0);
      step();
    end
    flush = 1'b0;
    drive(1'b0, 32'h0);
    out_ready = 1'b1;
    repeat (4) step();
    check("drain_empty", 32'(sb_q.size()), 32'd0);
    check("drain_out_valid", out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
